// File: rtl/fht_unload_if.sv
// fht_unload_if
//   Output stream of the FHT result reader: one signed sample per beat on a
//   valid/ready handshake.
//   oDATA  : signed sample, D_BIT wide
//   oIDX   : natural-order point index, I_BIT wide
//   oVALID : oDATA/oIDX/oLAST carry a beat
//   iREADY : consumer takes the beat when oVALID & iREADY
//   oLAST  : marks the final point of the transform
//   master : driven by fht_unload; slave : consumer side
interface fht_unload_if #(
  parameter int D_BIT = 16,
  parameter int I_BIT = 10
);
  logic [D_BIT-1:0] oDATA;
  logic [I_BIT-1:0] oIDX;
  logic             oVALID;
  logic             iREADY;
  logic             oLAST;

  modport master (output oDATA, output oIDX, output oVALID, output oLAST, input iREADY);
  modport slave  (input oDATA, input oIDX, input oVALID, input oLAST, output iREADY);
endinterface

// File: rtl/fht_unload.sv
// fht_unload
//   Result reader for fht_top. On iSTART it walks all N = 4*2**A_BIT points held
//   in the four RAM banks, undoing the bit-reversed storage order (BITREV=1), and
//   streams them out in natural order, one per beat, with an optional rounded
//   arithmetic right shift (1/N scaling after an inverse transform).
//   Ports:
//     iCLK, iRESET         clock, synchronous active-high reset
//     iSTART, iSHIFT       start pulse and shift amount (sampled at accepted start)
//     oADDR_RD_0..3        bank read address (all four carry the same value)
//     iDATA_0..3           bank read data, RAM_LAT cycles after the address
//     out_if               output stream (oDATA/oIDX/oVALID/iREADY/oLAST)
//     oBUSY, oDONE         unload in progress / one-cycle completion pulse

// Checker: the storage FIFO is sized so that a write into a full FIFO cannot happen.
module fht_unload_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic [CW-1:0] cnt
);
  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && (cnt == CW'(DEPTH))))
    else $error("fht_unload: push into full FIFO");
endmodule

module fht_unload #(
  parameter int D_BIT   = 16,
  parameter int A_BIT   = 8,
  parameter int RAM_LAT = 2,
  parameter int BITREV  = 1
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic [4:0]       iSHIFT,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  fht_unload_if.master     out_if,
  output logic             oBUSY,
  output logic             oDONE
);
  localparam int I_BIT = A_BIT + 2;
  // The output register counts as one FIFO entry, so total occupancy never exceeds DEPTH.
  localparam int DEPTH = RAM_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam logic [I_BIT-1:0] LAST_IDX = {I_BIT{1'b1}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_e;

  typedef struct packed {
    logic             vld;
    logic [1:0]       bank;
    logic [I_BIT-1:0] idx;
    logic             last;
  } tag_t;

  typedef struct packed {
    logic [D_BIT-1:0] data;
    logic [I_BIT-1:0] idx;
    logic             last;
  } beat_t;

  function automatic logic [I_BIT-1:0] bit_rev(input logic [I_BIT-1:0] v);
    logic [I_BIT-1:0] r;
    for (int i = 0; i < I_BIT; i++) r[i] = v[I_BIT-1-i];
    return r;
  endfunction

  // Round-half-up arithmetic shift in D_BIT+1 bits so the rounding add cannot overflow.
  function automatic logic [D_BIT-1:0] scale(input logic [D_BIT-1:0] x, input logic [4:0] sh);
    logic signed [D_BIT:0] ext;
    logic signed [D_BIT:0] rnd;
    logic signed [D_BIT:0] res;
    ext = signed'({x[D_BIT-1], x});
    if (sh == 5'd0) begin
      rnd = '0;
    end else begin
      rnd = signed'((D_BIT+1)'(1) << (sh - 5'd1));
    end
    res = (ext + rnd) >>> sh;
    if (int'(sh) >= D_BIT) begin
      return {D_BIT{x[D_BIT-1]}};
    end else begin
      return res[D_BIT-1:0];
    end
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  state_e           state_q, state_d;
  logic [I_BIT-1:0] cnt_q, cnt_d;
  logic [4:0]       shift_q, shift_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  tag_t             tag_q [RAM_LAT+1];
  tag_t             tag_d [RAM_LAT+1];
  beat_t            mem_q [DEPTH];
  beat_t            mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    scnt_q, scnt_d;
  beat_t            out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_acc_s;
  logic             pop_s;
  logic [CW:0]      occ_s;
  logic             issue_s;
  logic [I_BIT-1:0] issue_idx_s;
  logic [I_BIT-1:0] issue_k_s;
  logic             issue_last_s;
  logic             ret_s;
  logic [D_BIT-1:0] ret_raw_s;
  beat_t            ret_beat_s;
  logic             out_free_s;
  logic             stor_push_s;
  logic             stor_pop_s;

  assign start_acc_s  = (state_q == ST_IDLE) && iSTART;
  assign pop_s        = out_vld_q && out_if.iREADY;
  assign occ_s        = (CW+1)'(inflight_q) + (CW+1)'(scnt_q) + (CW+1)'(out_vld_q);
  // A beat leaving this cycle frees a slot, which keeps 1 beat/cycle with iREADY high.
  assign issue_s      = start_acc_s ||
                        ((state_q == ST_RUN) && ((occ_s < (CW+1)'(DEPTH)) || pop_s));
  assign issue_idx_s  = (state_q == ST_IDLE) ? {I_BIT{1'b0}} : cnt_q;
  assign issue_k_s    = (BITREV != 0) ? bit_rev(issue_idx_s) : issue_idx_s;
  assign issue_last_s = (issue_idx_s == LAST_IDX);
  assign ret_s        = tag_q[RAM_LAT].vld;
  assign out_free_s   = !out_vld_q || pop_s;
  // Returning data bypasses storage only when storage holds nothing older.
  assign stor_pop_s   = out_free_s && (scnt_q != CW'(0));
  assign stor_push_s  = ret_s && !(out_free_s && (scnt_q == CW'(0)));

  // Bank select for the entry leaving the tag pipeline.
  always_comb begin
    ret_raw_s = iDATA_0;
    case (tag_q[RAM_LAT].bank)
      2'd0:    ret_raw_s = iDATA_0;
      2'd1:    ret_raw_s = iDATA_1;
      2'd2:    ret_raw_s = iDATA_2;
      2'd3:    ret_raw_s = iDATA_3;
      default: ret_raw_s = iDATA_0;
    endcase
    ret_beat_s.data = scale(ret_raw_s, shift_q);
    ret_beat_s.idx  = tag_q[RAM_LAT].idx;
    ret_beat_s.last = tag_q[RAM_LAT].last;
  end

  // Read issue: address, issue counter, in-flight count and tag pipeline.
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    inflight_d = inflight_q + CW'(issue_s) - CW'(ret_s);
    tag_d[0]   = '0;
    for (int i = 1; i <= RAM_LAT; i++) tag_d[i] = tag_q[i-1];
    if (start_acc_s) begin
      shift_d = iSHIFT;
    end else begin
      shift_d = shift_q;
    end
    if (issue_s) begin
      cnt_d         = issue_idx_s + I_BIT'(1);
      addr_d        = issue_k_s[I_BIT-1:2];
      tag_d[0].vld  = 1'b1;
      tag_d[0].bank = issue_k_s[1:0];
      tag_d[0].idx  = issue_idx_s;
      tag_d[0].last = issue_last_s;
    end else begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
    end
  end

  // Storage FIFO plus FWFT output register.
  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    scnt_d    = scnt_q + CW'(stor_push_s) - CW'(stor_pop_s);
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (stor_push_s) begin
      mem_d[wr_q] = ret_beat_s;
      wr_d        = ptr_inc(wr_q);
    end else begin
      wr_d = wr_q;
    end
    if (stor_pop_s) begin
      out_d     = mem_q[rd_q];
      out_vld_d = 1'b1;
      rd_d      = ptr_inc(rd_q);
    end else if (out_free_s && ret_s) begin
      out_d     = ret_beat_s;
      out_vld_d = 1'b1;
    end else if (out_free_s) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Control FSM next state; busy/done are registered from the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (iSTART) state_d = ST_RUN; else state_d = ST_IDLE;
      ST_RUN:   if (issue_s && issue_last_s) state_d = ST_DRAIN; else state_d = ST_RUN;
      ST_DRAIN: if (pop_s && out_q.last) state_d = ST_DONE; else state_d = ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // DONE keeps oBUSY high so a start arriving with oDONE is ignored.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State registers with synchronous reset; reset drops anything still in flight.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= 5'd0;
      addr_q     <= '0;
      inflight_q <= '0;
      for (int i = 0; i <= RAM_LAT; i++) tag_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      scnt_q     <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      for (int i = 0; i <= RAM_LAT; i++) tag_q[i] <= tag_d[i];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      scnt_q     <= scnt_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign oADDR_RD_0    = addr_q;
  assign oADDR_RD_1    = addr_q;
  assign oADDR_RD_2    = addr_q;
  assign oADDR_RD_3    = addr_q;
  assign out_if.oDATA  = out_q.data;
  assign out_if.oIDX   = out_q.idx;
  assign out_if.oLAST  = out_q.last;
  assign out_if.oVALID = out_vld_q;
  assign oBUSY         = busy_q;
  assign oDONE         = done_q;

  fht_unload_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk  (iCLK),
    .rst  (iRESET),
    .push (stor_push_s),
    .cnt  (scnt_q)
  );
endmodule

// File: tb/tb_fht_unload.sv
module tb_fht_unload;
  localparam int D = 16;
  localparam int A = 3;
  localparam int I = 5;
  localparam int N = 32;
  localparam int LAT_T [3] = '{2, 1, 4};
  localparam int BR_T  [3] = '{1, 0, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = 3'b000;
  logic [2:0] rdy = 3'b111;
  logic [2:0] vld, last, busy, done;
  logic [2:0][D-1:0] dat;
  logic [2:0][I-1:0] idx;
  logic [4:0] shift = 5'd0;
  logic neg = 1'b0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [I-1:0] idx;
    logic [D-1:0] data;
    logic         last;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  // Three builds: main (BITREV=1, LAT=2), natural order LAT=1 and LAT=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = LAT_T[g];
    fht_unload_if #(.D_BIT(D), .I_BIT(I)) u_if ();
    logic [A-1:0] a [4];
    logic [D-1:0] d [4];

    fht_unload #(.D_BIT(D), .A_BIT(A), .RAM_LAT(L), .BITREV(BR_T[g])) u_dut (
      .iCLK(clk), .iRESET(rst), .iSTART(start[g]), .iSHIFT(shift),
      .oADDR_RD_0(a[0]), .oADDR_RD_1(a[1]), .oADDR_RD_2(a[2]), .oADDR_RD_3(a[3]),
      .iDATA_0(d[0]), .iDATA_1(d[1]), .iDATA_2(d[2]), .iDATA_3(d[3]),
      .out_if(u_if), .oBUSY(busy[g]), .oDONE(done[g])
    );

    assign u_if.iREADY = rdy[g];
    assign vld[g]  = u_if.oVALID;
    assign last[g] = u_if.oLAST;
    assign dat[g]  = u_if.oDATA;
    assign idx[g]  = u_if.oIDX;

    // RAM model: x[k] = k (or -k), read data L cycles after address.
    for (genvar b = 0; b < 4; b++) begin : g_bank
      logic [A-1:0] ap [L];
      logic [I-1:0] k;
      always @(posedge clk) begin
        ap[0] <= a[b];
        for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
      end
      assign k    = {ap[L-1], 2'(b)};
      assign d[b] = neg ? (16'd0 - 16'(k)) : 16'(k);
    end
  end

  function automatic int rev5(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) if (((n >> i) & 1) != 0) r = r | (1 << (4 - i));
    return r;
  endfunction

  function automatic logic [D-1:0] model_scale(input int x, input int s);
    int t;
    if (s == 0) t = x;
    else if (s >= D) t = (x < 0) ? -1 : 0;
    else t = (x + (1 << (s - 1))) >>> s;
    return t[D-1:0];
  endfunction

  // Start DUT g, push expected beats, then consume with the chosen iREADY pattern.
  // xstart: cycle of an extra start pulse (0 none, -2 on the oDONE cycle).
  // abort_at: beat count at which reset is raised and the task returns (0 none).
  task automatic run_unload(input int g, input int rmode, input int xstart, input int abort_at,
                            output int beats, output int dones, output int first, output int lasths);
    logic [D-1:0] hd;
    logic [I-1:0] hi;
    logic hl;
    bit held;
    bit r;
    beat_t e;
    beats = 0; dones = 0; first = -1; lasths = -1; held = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    @(negedge clk);
    start[g] = 1'b1;
    for (int n = 0; n < N; n++) begin
      int k;
      k = (BR_T[g] != 0) ? rev5(n) : n;
      e.idx  = I'(n);
      e.data = model_scale(neg ? -k : k, int'(shift));
      e.last = (n == N - 1);
      exp_q.push_back(e);
    end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start[g] = ((cyc == xstart) || (xstart == -2 && lasths > 0 && cyc == lasths + 1)) ? 1'b1 : 1'b0;
      if (done[g]) dones++;
      if (lasths > 0 && cyc == lasths + 1) begin
        checks++;
        if (done[g] !== 1'b1) begin
          failures++;
          $display("FAIL done_pulse g=%0d got=%b exp=1", g, done[g]);
        end
      end
      if (held) begin
        checks++;
        if ({vld[g], dat[g], idx[g], last[g]} !== {1'b1, hd, hi, hl}) begin
          failures++;
          $display("FAIL stall_hold g=%0d got vld=%b data=%0h idx=%0d exp vld=1 data=%0h idx=%0d",
                   g, vld[g], dat[g], idx[g], hd, hi);
        end
      end
      if (vld[g] && first < 0) first = cyc;
      if (rmode == 0) r = 1'b1;
      else if (cyc < 24) r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else r = 1'($urandom_range(0, 1));
      rdy[g] = r;
      held = 1'b0;
      if (vld[g] && r) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat g=%0d got idx=%0d exp none", g, idx[g]);
        end else begin
          e = exp_q.pop_front();
          if (idx[g] !== e.idx || dat[g] !== e.data || last[g] !== e.last) begin
            failures++;
            $display("FAIL beat g=%0d got idx=%0d data=%0h last=%b exp idx=%0d data=%0h last=%b",
                     g, idx[g], dat[g], last[g], e.idx, e.data, e.last);
          end
        end
        if (last[g]) lasths = cyc;
        if (beats == abort_at) begin
          rst = 1'b1;
          return;
        end
      end else if (vld[g]) begin
        held = 1'b1; hd = dat[g]; hi = idx[g]; hl = last[g];
      end
      if (lasths > 0 && cyc >= lasths + 3) break;
    end
    rdy[g] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({vld[g], last[g], busy[g], done[g], dat[g], idx[g]} !== '0) begin
        failures++;
        $display("FAIL reset_state g=%0d got vld=%b busy=%b done=%b data=%0h exp all 0",
                 g, vld[g], busy[g], done[g], dat[g]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bitrev_stream();
    int beats, dones, first, lasths;
    neg = 1'b0; shift = 5'd0;
    run_unload(0, 0, 0, 0, beats, dones, first, lasths);
    checks++;
    if (first != LAT_T[0] + 2 || lasths - first != N - 1 || beats != N || dones != 1) begin
      failures++;
      $display("FAIL bitrev_stream got first=%0d span=%0d beats=%0d dones=%0d exp first=%0d span=%0d beats=%0d dones=1",
               first, lasths - first, beats, dones, LAT_T[0] + 2, N - 1, N);
    end
    checks++;
    if (exp_q.size() != 0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL bitrev_end got left=%0d busy=%b exp left=0 busy=0", exp_q.size(), busy[0]);
    end
  endtask

  task automatic test_stall();
    int beats, dones, first, lasths;
    neg = 1'b0; shift = 5'd0;
    run_unload(0, 1, 0, 0, beats, dones, first, lasths);
    checks++;
    if (beats != N || dones != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_count got beats=%0d dones=%0d left=%0d exp beats=%0d dones=1 left=0",
               beats, dones, exp_q.size(), N);
    end
  endtask

  // Natural order with scaling, on the LAT=1 and LAT=4 builds; also checks latency and no bubbles.
  task automatic test_scale_latency();
    int beats, dones, first, lasths;
    for (int t = 0; t < 3; t++) begin
      int g;
      g = (t == 1) ? 2 : 1;
      neg   = (t != 1);
      shift = (t == 0) ? 5'd5 : ((t == 1) ? 5'd3 : 5'd20);
      run_unload(g, (t == 2) ? 1 : 0, 0, 0, beats, dones, first, lasths);
      checks++;
      if (beats != N || dones != 1 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL scale_count t=%0d got beats=%0d dones=%0d exp beats=%0d dones=1", t, beats, dones, N);
      end
      if (t != 2) begin
        checks++;
        if (first != LAT_T[g] + 2 || lasths - first != N - 1) begin
          failures++;
          $display("FAIL latency g=%0d got first=%0d span=%0d exp first=%0d span=%0d",
                   g, first, lasths - first, LAT_T[g] + 2, N - 1);
        end
      end
    end
  endtask

  task automatic test_abort();
    int beats, dones, first, lasths;
    int bad;
    neg = 1'b0; shift = 5'd0;
    run_unload(0, 0, 0, 10, beats, dones, first, lasths);
    @(negedge clk);
    checks++;
    if (vld[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_now got vld=%b busy=%b done=%b exp 0 0 0", vld[0], busy[0], done[0]);
    end
    rst = 1'b0;
    rdy[0] = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (vld[0] || done[0]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet got activity=%0d exp 0", bad);
    end
    exp_q.delete();
    run_unload(0, 0, 0, 0, beats, dones, first, lasths);
    checks++;
    if (beats != N || dones != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart got beats=%0d dones=%0d exp beats=%0d dones=1", beats, dones, N);
    end
  endtask

  task automatic test_ignored_starts();
    int beats, dones, first, lasths;
    int bad;
    neg = 1'b0; shift = 5'd0;
    run_unload(0, 0, 5, 0, beats, dones, first, lasths);
    checks++;
    if (beats != N || dones != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL start_in_run got beats=%0d dones=%0d exp beats=%0d dones=1", beats, dones, N);
    end
    run_unload(0, 0, -2, 0, beats, dones, first, lasths);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (vld[0] || busy[0]) bad++;
    end
    checks++;
    if (bad != 0 || beats != N || dones != 1) begin
      failures++;
      $display("FAIL start_on_done got activity=%0d beats=%0d dones=%0d exp 0 %0d 1", bad, beats, dones, N);
    end
  endtask

  initial begin
    test_reset();
    test_bitrev_stream();
    test_stall();
    test_scale_latency();
    test_abort();
    test_ignored_starts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
